// File: rtl/cla_pkg.sv
// cla_pkg: shared constants and helpers for the registered carry-lookahead adder.
//   GROUP_W : number of bits covered by one lookahead group.
//   REF_W   : operand width the reference function is built for (the default adder width).
//   ref_add : plain arithmetic x + y + cin in REF_W+1 bits, used to check the adder.
package cla_pkg;

    localparam int GROUP_W = 3;
    localparam int REF_W   = 9;

    // Straight arithmetic reference; deliberately independent of the lookahead structure.
    function automatic logic [REF_W:0] ref_add(
        input logic [REF_W-1:0] x,
        input logic [REF_W-1:0] y,
        input logic             cin
    );
        return {1'b0, x} + {1'b0, y} + {{REF_W{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/cla_reg_adder_cll.sv
// cll: 3-bit carry-lookahead unit.
//   c      : carry into the group (carry into its bit 0)
//   g, p   : per-bit generate/propagate of the three bits
//   c_i    : carries into bits 1 and 2, and c_i[3] the group carry-out
module cll
    import cla_pkg::*;
(
    input  logic               c,
    input  logic [GROUP_W-1:0] g,
    input  logic [GROUP_W-1:0] p,
    output logic [GROUP_W:1]   c_i
);

    // Every carry is a flat sum-of-products of the group inputs, so no carry
    // inside the group waits on a lower carry of the same group.
    assign c_i[1] = g[0] | (p[0] & c);
    assign c_i[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    assign c_i[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c);

endmodule

// File: rtl/cla_reg_adder_fapg.sv
// fapg: single-bit adder cell producing propagate, generate and sum.
//   x, y : addend bits
//   c    : carry into this bit
//   p    : propagate (x ^ y)
//   g    : generate  (x & y)
//   s    : sum bit   (p ^ c)
module fapg (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic p,
    output logic g,
    output logic s
);

    // p and g depend only on the operands, so the lookahead unit can use them
    // without waiting on the carry that this cell later consumes.
    assign p = x ^ y;
    assign g = x & y;
    assign s = p ^ c;

endmodule

// File: rtl/cla_reg_adder.sv
// cla_reg_adder: one-cycle-latency carry-lookahead adder stage with a valid qualifier.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, clears sum/cout/out_valid
//   in_valid  : x, y, cin are valid this cycle
//   cin       : carry into bit 0
//   x, y      : WIDTH-bit unsigned addends
//   out_valid : sum/cout hold the result of an operation captured at the last edge
//   sum       : registered low WIDTH bits of x + y + cin
//   cout      : registered carry out of bit WIDTH-1
module cla_reg_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NGROUPS = WIDTH / GROUP_W;

    // The group structure only works when the operand splits evenly into groups.
    if (((WIDTH % GROUP_W) != 0) || (WIDTH < GROUP_W)) begin : g_bad_width
        $error("cla_reg_adder: WIDTH must be a positive multiple of 3");
    end

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;

    // Each group keeps its own carry signals in its own scope; the next group
    // picks up the previous group's carry-out, giving a group-serial chain.
    for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
        logic               w_cin;
        logic [GROUP_W:1]   w_ci;
        logic [GROUP_W-1:0] w_bc;
        logic [GROUP_W-1:0] w_p;
        logic [GROUP_W-1:0] w_g;
        logic [GROUP_W-1:0] w_s;

        if (k == 0) begin : g_first
            assign w_cin = cin;
        end else begin : g_chain
            assign w_cin = g_grp[k-1].w_ci[GROUP_W];
        end

        // Carry into each bit of the group: group carry-in for bit 0, lookahead for the rest.
        assign w_bc = {w_ci[GROUP_W-1:1], w_cin};

        for (genvar b = 0; b < GROUP_W; b++) begin : g_bit
            fapg u_fapg (
                .x (x[GROUP_W*k + b]),
                .y (y[GROUP_W*k + b]),
                .c (w_bc[b]),
                .p (w_p[b]),
                .g (w_g[b]),
                .s (w_s[b])
            );
        end

        cll u_cll (
            .c   (w_cin),
            .g   (w_g),
            .p   (w_p),
            .c_i (w_ci)
        );

        assign w_sum[GROUP_W*k +: GROUP_W] = w_s;
    end

    assign w_cout = g_grp[NGROUPS-1].w_ci[GROUP_W];

    // Result registers: capture on a valid cycle, otherwise hold the last result
    // and drop out_valid. Reset clears everything, discarding any pending capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_cla_reg_adder.sv
// tb_cla_reg_adder: self-checking bench for cla_reg_adder (WIDTH = 9) plus
// exhaustive checks of the cll lookahead unit and the fapg bit cell.
module tb_cla_reg_adder;
    import cla_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       inValid;
    logic       cinIn;
    logic [8:0] xIn;
    logic [8:0] yIn;
    logic       outValid;
    logic [8:0] sumOut;
    logic       coutOut;

    logic       tbC;
    logic [2:0] tbG;
    logic [2:0] tbP;
    logic [3:1] tbCi;

    logic       fx;
    logic       fy;
    logic       fc;
    logic       fp;
    logic       fg;
    logic       fs;

    int checkCount = 0;
    int errorCount = 0;

    cla_reg_adder #(.WIDTH(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .cin       (cinIn),
        .x         (xIn),
        .y         (yIn),
        .out_valid (outValid),
        .sum       (sumOut),
        .cout      (coutOut)
    );

    cll u_cll (
        .c   (tbC),
        .g   (tbG),
        .p   (tbP),
        .c_i (tbCi)
    );

    fapg u_fapg (
        .x (fx),
        .y (fy),
        .c (fc),
        .p (fp),
        .g (fg),
        .s (fs)
    );

    // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive operands after the falling edge, then wait for the capturing edge
    // and settle just past it so outputs can be sampled.
    task automatic applyStimulus(input logic [8:0] ax, input logic [8:0] ay,
                                 input logic ac, input logic av);
        @(negedge clk);
        xIn     = ax;
        yIn     = ay;
        cinIn   = ac;
        inValid = av;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResult(input string tag, input logic [8:0] expSum,
                               input logic expCout, input logic expValid);
        checkOutput({tag, ".sum"},   32'(sumOut),   32'(expSum));
        checkOutput({tag, ".cout"},  32'(coutOut),  32'(expCout));
        checkOutput({tag, ".valid"}, 32'(outValid), 32'(expValid));
    endtask

    initial begin
        logic [8:0] expSum;
        logic       expCout;
        logic       expValid;
        logic [9:0] full;
        logic [8:0] rx;
        logic [8:0] ry;
        logic       rc;
        logic       rv;
        logic [3:0] grp;
        logic [3:1] expCi;

        rst_n   = 1'b1;
        inValid = 1'b0;
        cinIn   = 1'b0;
        xIn     = '0;
        yIn     = '0;
        tbC     = 1'b0;
        tbG     = '0;
        tbP     = '0;
        fx      = 1'b0;
        fy      = 1'b0;
        fc      = 1'b0;

        // Exhaustive lookahead unit: carries must match plain 3-bit arithmetic.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    tbP = 3'(a ^ b);
                    tbG = 3'(a & b);
                    tbC = c[0];
                    #1;
                    for (int i = 1; i <= 3; i++) begin
                        grp = 4'(((a & ((1 << i) - 1)) + (b & ((1 << i) - 1)) + c) >> i);
                        expCi[i] = grp[0];
                    end
                    checkOutput($sformatf("cll a=%0d b=%0d c=%0d", a, b, c),
                                32'(tbCi), 32'(expCi));
                end
            end
        end

        // Exhaustive bit cell.
        for (int v = 0; v < 8; v++) begin
            fx = v[2];
            fy = v[1];
            fc = v[0];
            #1;
            grp = 4'(v[2] + v[1] + v[0]);
            checkOutput($sformatf("fapg v=%0d", v), 32'({fp, fg, fs}),
                        32'({v[2] ^ v[1], v[2] & v[1], grp[0]}));
        end

        // Reset with in_valid high, before any clock edge.
        @(negedge clk);
        rst_n   = 1'b0;
        inValid = 1'b1;
        xIn     = 9'h1FF;
        yIn     = 9'h1FF;
        cinIn   = 1'b1;
        #1;
        checkResult("reset_init", 9'h000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkResult("reset_edge", 9'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        applyStimulus(9'h1FF, 9'h000, 1'b1, 1'b1);
        checkResult("full_chain", 9'h000, 1'b1, 1'b1);
        applyStimulus(9'h007, 9'h001, 1'b0, 1'b1);
        checkResult("grp_prop_c0", 9'h008, 1'b0, 1'b1);
        applyStimulus(9'h007, 9'h001, 1'b1, 1'b1);
        checkResult("grp_prop_c1", 9'h009, 1'b0, 1'b1);
        applyStimulus(9'h1FF, 9'h1FF, 1'b1, 1'b1);
        checkResult("max_ops", 9'h1FF, 1'b1, 1'b1);
        applyStimulus(9'h000, 9'h000, 1'b0, 1'b1);
        checkResult("zeros", 9'h000, 1'b0, 1'b1);
        applyStimulus(9'h0AA, 9'h055, 1'b0, 1'b1);
        checkResult("b2b_first", 9'h0FF, 1'b0, 1'b1);
        applyStimulus(9'h100, 9'h100, 1'b0, 1'b1);
        checkResult("b2b_second", 9'h000, 1'b1, 1'b1);
        applyStimulus(9'h123, 9'h045, 1'b1, 1'b0);
        checkResult("hold", 9'h000, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        applyStimulus(9'h0F0, 9'h00F, 1'b0, 1'b1);
        checkResult("pre_reset", 9'h0FF, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResult("async_reset", 9'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random sweep with random in_valid and a reset pulse halfway through.
        expSum   = 9'h000;
        expCout  = 1'b0;
        expValid = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            if (n == 5000) begin
                @(negedge clk);
                rst_n   = 1'b0;
                inValid = 1'b1;
                xIn     = 9'h1FF;
                yIn     = 9'h001;
                cinIn   = 1'b1;
                #1;
                checkResult("sweep_rst_async", 9'h000, 1'b0, 1'b0);
                @(posedge clk);
                #1;
                checkResult("sweep_rst_edge", 9'h000, 1'b0, 1'b0);
                @(negedge clk);
                rst_n   = 1'b1;
                inValid = 1'b0;
                @(posedge clk);
                #1;
                checkResult("sweep_rst_release", 9'h000, 1'b0, 1'b0);
                expSum   = 9'h000;
                expCout  = 1'b0;
                expValid = 1'b0;
            end
            rx = 9'($urandom);
            ry = 9'($urandom);
            rc = 1'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            applyStimulus(rx, ry, rc, rv);
            if (rv) begin
                full    = ref_add(rx, ry, rc);
                expSum  = full[8:0];
                expCout = full[9];
            end
            expValid = rv;
            checkResult($sformatf("sweep%0d", n), expSum, expCout, expValid);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
